// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bundles the four req/ack ports of regfile_mp plus the
// busy scoreboard.
//   ra_*  : read port A  (req, idx -> ack, data)
//   rb_*  : read port B  (req, idx -> ack, data)
//   w_*   : write port   (req, idx, data -> ack)
//   rsv_* : reserve port (req, idx -> ack)
//   busy_vec : registered scoreboard, bit i = register i busy
// master = requester (issue/writeback side), slave = register file.
interface regfile_mp_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned IDX_W    = 5
);
  logic                ra_req;
  logic [IDX_W-1:0]    ra_idx;
  logic                ra_ack;
  logic [DATA_W-1:0]   ra_data;
  logic                rb_req;
  logic [IDX_W-1:0]    rb_idx;
  logic                rb_ack;
  logic [DATA_W-1:0]   rb_data;
  logic                w_req;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_data;
  logic                w_ack;
  logic                rsv_req;
  logic [IDX_W-1:0]    rsv_idx;
  logic                rsv_ack;
  logic [NUM_REGS-1:0] busy_vec;

  modport master (
    output ra_req, ra_idx, rb_req, rb_idx, w_req, w_idx, w_data, rsv_req, rsv_idx,
    input  ra_ack, ra_data, rb_ack, rb_data, w_ack, rsv_ack, busy_vec
  );

  modport slave (
    input  ra_req, ra_idx, rb_req, rb_idx, w_req, w_idx, w_data, rsv_req, rsv_idx,
    output ra_ack, ra_data, rb_ack, rb_data, w_ack, rsv_ack, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with busy scoreboard.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : regfile_mp_if.slave -- two read ports, one write port, one
//           reserve port (all req/ack, registered 1-cycle ack pulse) and
//           the registered busy_vec scoreboard.
// Register 0 reads as zero; indices >= NUM_REGS read as zero and are
// ignored on write/reserve. Busy reads/reserves stall until the register
// is written; BYPASS forwards a same-cycle write to a stalled or plain read.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned SP_IDX   = 2,
  parameter logic [31:0] SP_INIT  = 32'h0001_0000,
  parameter int unsigned BYPASS   = 1
) (
  input logic        clk,
  input logic        rst_n,
  regfile_mp_if.slave bus
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                ra_ack_q, ra_ack_d, rb_ack_q, rb_ack_d;
  logic                w_ack_q, w_ack_d, rsv_ack_q, rsv_ack_d;
  logic [DATA_W-1:0]   ra_data_q, ra_data_d, rb_data_q, rb_data_d;

  logic w_hit, byp_a, byp_b, ra_fire, rb_fire, rsv_fire;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return (idx != '0) && (32'(idx) < NUM_REGS);
  endfunction

  // Decoded by compare rather than direct indexing so that IDX_W wider
  // than the array never produces an out-of-bounds select.
  function automatic logic busy_of(input logic [IDX_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int unsigned i = 1; i < NUM_REGS; i++)
      if (idx == IDX_W'(i)) b = busy_q[i];
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] reg_of(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++)
      if (idx == IDX_W'(i)) v = regs_q[i];
    return v;
  endfunction

  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    ra_data_d = ra_data_q;
    rb_data_d = rb_data_q;

    w_ack_d = bus.w_req && !w_ack_q;
    w_hit   = w_ack_d && in_range(bus.w_idx);

    byp_a = (BYPASS != 0) && w_hit && (bus.ra_idx == bus.w_idx);
    byp_b = (BYPASS != 0) && w_hit && (bus.rb_idx == bus.w_idx);

    ra_fire = bus.ra_req && !ra_ack_q && (!busy_of(bus.ra_idx) || byp_a);
    rb_fire = bus.rb_req && !rb_ack_q && (!busy_of(bus.rb_idx) || byp_b);
    ra_ack_d = ra_fire;
    rb_ack_d = rb_fire;
    if (ra_fire) ra_data_d = byp_a ? bus.w_data : reg_of(bus.ra_idx);
    if (rb_fire) rb_data_d = byp_b ? bus.w_data : reg_of(bus.rb_idx);

    // Reserve sees start-of-cycle busy, so a write clearing the same
    // index this cycle still stalls it once.
    rsv_fire  = bus.rsv_req && !rsv_ack_q && !busy_of(bus.rsv_idx);
    rsv_ack_d = rsv_fire;

    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (w_hit && (bus.w_idx == IDX_W'(i))) begin
        regs_d[i] = bus.w_data;
        busy_d[i] = 1'b0;
      end
      if (rsv_fire && (bus.rsv_idx == IDX_W'(i)))
        busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs_q[i] <= ((SP_IDX != 0) && (i == SP_IDX)) ? DATA_W'(SP_INIT) : '0;
      busy_q    <= '0;
      ra_ack_q  <= 1'b0;
      rb_ack_q  <= 1'b0;
      w_ack_q   <= 1'b0;
      rsv_ack_q <= 1'b0;
      ra_data_q <= '0;
      rb_data_q <= '0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      ra_ack_q  <= ra_ack_d;
      rb_ack_q  <= rb_ack_d;
      w_ack_q   <= w_ack_d;
      rsv_ack_q <= rsv_ack_d;
      ra_data_q <= ra_data_d;
      rb_data_q <= rb_data_d;
    end
  end

  assign bus.ra_ack   = ra_ack_q;
  assign bus.ra_data  = ra_data_q;
  assign bus.rb_ack   = rb_ack_q;
  assign bus.rb_data  = rb_data_q;
  assign bus.w_ack    = w_ack_q;
  assign bus.rsv_ack  = rsv_ack_q;
  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with BYPASS=1 and one with
// BYPASS=0 share stimulus (separate read-A requests so each can drop its
// request on its own ack). IDX_W=6 so index 33 is reachable.
module tb_regfile_mp;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned IW = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          ra_req1, ra_req0, rb_req, w_req, rsv_req;
  logic [IW-1:0] ra_idx, rb_idx, w_idx, rsv_idx;
  logic [DW-1:0] w_data;

  regfile_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .IDX_W(IW)) bus1 ();
  regfile_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .IDX_W(IW)) bus0 ();

  assign bus1.ra_req  = ra_req1;
  assign bus0.ra_req  = ra_req0;
  assign bus1.ra_idx  = ra_idx;
  assign bus0.ra_idx  = ra_idx;
  assign bus1.rb_req  = rb_req;
  assign bus0.rb_req  = rb_req;
  assign bus1.rb_idx  = rb_idx;
  assign bus0.rb_idx  = rb_idx;
  assign bus1.w_req   = w_req;
  assign bus0.w_req   = w_req;
  assign bus1.w_idx   = w_idx;
  assign bus0.w_idx   = w_idx;
  assign bus1.w_data  = w_data;
  assign bus0.w_data  = w_data;
  assign bus1.rsv_req = rsv_req;
  assign bus0.rsv_req = rsv_req;
  assign bus1.rsv_idx = rsv_idx;
  assign bus0.rsv_idx = rsv_idx;

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .IDX_W(IW), .SP_IDX(2),
               .SP_INIT(32'h0001_0000), .BYPASS(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .IDX_W(IW), .SP_IDX(2),
               .SP_INIT(32'h0001_0000), .BYPASS(0))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [IW-1:0] idx, input logic [DW-1:0] d, input string tag);
    w_req = 1'b1; w_idx = idx; w_data = d;
    step();
    chk(tag, 32'(bus1.w_ack), 32'd1);
    w_req = 1'b0;
    step();
  endtask

  task automatic read_a(input logic [IW-1:0] idx, input logic [DW-1:0] exp, input string tag);
    ra_req1 = 1'b1; ra_idx = idx;
    step();
    chk({tag, "_ack"}, 32'(bus1.ra_ack), 32'd1);
    chk({tag, "_data"}, bus1.ra_data, exp);
    ra_req1 = 1'b0;
    step();
  endtask

  int acks;

  initial begin
    rst_n = 1'b0;
    ra_req1 = 1'b0; ra_req0 = 1'b0; rb_req = 1'b0; w_req = 1'b0; rsv_req = 1'b0;
    ra_idx = '0; rb_idx = '0; w_idx = '0; rsv_idx = '0; w_data = '0;
    repeat (2) step();
    chk("rst_ra_ack", 32'(bus1.ra_ack), 32'd0);
    chk("rst_w_ack", 32'(bus1.w_ack), 32'd0);
    chk("rst_busy", bus1.busy_vec, 32'd0);
    chk("rst_ra_data", bus1.ra_data, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: SP reset value and zero register
    ra_req1 = 1'b1; ra_idx = 6'd2; rb_req = 1'b1; rb_idx = 6'd5;
    step();
    chk("t1_ra_ack", 32'(bus1.ra_ack), 32'd1);
    chk("t1_ra_data", bus1.ra_data, 32'h0001_0000);
    chk("t1_rb_ack", 32'(bus1.rb_ack), 32'd1);
    chk("t1_rb_data", bus1.rb_data, 32'd0);
    ra_req1 = 1'b0; rb_req = 1'b0;
    step();
    chk("t1_ack_pulse", 32'(bus1.ra_ack), 32'd0);

    // 2: write then dual read; register 0 stays zero
    do_write(6'd7, 32'hDEAD_BEEF, "t2_w7_ack");
    ra_req1 = 1'b1; ra_idx = 6'd7; rb_req = 1'b1; rb_idx = 6'd7;
    step();
    chk("t2_ra_data", bus1.ra_data, 32'hDEAD_BEEF);
    chk("t2_rb_data", bus1.rb_data, 32'hDEAD_BEEF);
    chk("t2_rb_ack", 32'(bus1.rb_ack), 32'd1);
    ra_req1 = 1'b0; rb_req = 1'b0;
    step();
    do_write(6'd0, 32'h1234, "t2_w0_ack");
    read_a(6'd0, 32'd0, "t2_r0");

    // 3: busy read stalls until the write; bypass vs no bypass
    rsv_req = 1'b1; rsv_idx = 6'd4;
    step();
    chk("t3_rsv_ack", 32'(bus1.rsv_ack), 32'd1);
    chk("t3_busy4", 32'(bus1.busy_vec[4]), 32'd1);
    rsv_req = 1'b0;
    step();
    ra_req1 = 1'b1; ra_req0 = 1'b1; ra_idx = 6'd4;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      acks += int'(bus1.ra_ack) + int'(bus0.ra_ack);
    end
    chk("t3_stall_acks", 32'(acks), 32'd0);
    w_req = 1'b1; w_idx = 6'd4; w_data = 32'h55;
    step();
    chk("t3_b1_ack", 32'(bus1.ra_ack), 32'd1);
    chk("t3_b1_data", bus1.ra_data, 32'h55);
    chk("t3_b1_busy4", 32'(bus1.busy_vec[4]), 32'd0);
    chk("t3_b0_ack_early", 32'(bus0.ra_ack), 32'd0);
    w_req = 1'b0; ra_req1 = 1'b0;
    step();
    chk("t3_b0_ack", 32'(bus0.ra_ack), 32'd1);
    chk("t3_b0_data", bus0.ra_data, 32'h55);
    chk("t3_b1_no_reack", 32'(bus1.ra_ack), 32'd0);
    ra_req0 = 1'b0;
    step();

    // 4: WAW stall on reserve; write in the retry cycle
    rsv_req = 1'b1; rsv_idx = 6'd9;
    step();
    chk("t4_rsv1_ack", 32'(bus1.rsv_ack), 32'd1);
    rsv_req = 1'b0;
    step();
    rsv_req = 1'b1;
    step();
    chk("t4_rsv2_stall", 32'(bus1.rsv_ack), 32'd0);
    w_req = 1'b1; w_idx = 6'd9; w_data = 32'h99;
    step();
    chk("t4_w_ack", 32'(bus1.w_ack), 32'd1);
    chk("t4_rsv_still_stall", 32'(bus1.rsv_ack), 32'd0);
    w_req = 1'b0;
    step();
    chk("t4_rsv2_ack", 32'(bus1.rsv_ack), 32'd1);
    rsv_req = 1'b0;
    step();
    chk("t4_busy_vec", bus1.busy_vec, 32'h0000_0200);

    // 5: out-of-range index
    read_a(6'd33, 32'd0, "t5_r33");
    do_write(6'd33, 32'hFFFF, "t5_w33_ack");
    read_a(6'd1, 32'd0, "t5_r1_alias");

    // 6: reset during a stalled read
    read_a(6'd7, 32'hDEAD_BEEF, "t6_pre");
    ra_req1 = 1'b1; ra_req0 = 1'b1; ra_idx = 6'd9;
    step();
    chk("t6_stalled", 32'(bus1.ra_ack), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ack", 32'(bus1.ra_ack), 32'd0);
    chk("t6_rst_data", bus1.ra_data, 32'd0);
    chk("t6_rst_busy", bus1.busy_vec, 32'd0);
    #2;
    rb_req = 1'b1; rb_idx = 6'd2;
    rst_n = 1'b1;
    step();
    chk("t6_ra_ack", 32'(bus1.ra_ack), 32'd1);
    chk("t6_ra_data", bus1.ra_data, 32'd0);
    chk("t6_rb_sp", bus1.rb_data, 32'h0001_0000);
    chk("t6_busy", bus1.busy_vec, 32'd0);
    ra_req1 = 1'b0; ra_req0 = 1'b0; rb_req = 1'b0;
    step();
    read_a(6'd7, 32'd0, "t6_r7_cleared");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file: two independent read ports, one write port and one reservation port. Each port uses a req/ack handshake.
- Adds over the single-port register file:
  - configurable width and depth
  - stack-pointer reset value
  - per-register busy scoreboard that stalls hazardous reads and reserves
  - optional write-to-read bypass
- Sits between the decode/issue stage and the writeback stage of the CPU core.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (index 0 hardwired to zero)
IDX_W, 5, index width; must satisfy 2**IDX_W >= NUM_REGS
SP_IDX, 2, register loaded with SP_INIT at reset (ignored if 0)
SP_INIT, 32'h00010000, stack-pointer reset value, truncated or zero-extended to DATA_W
BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = no forwarding

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
ra_req  input  1  read port A request, level, held until ra_ack
ra_idx  input  IDX_W  read port A register index
ra_ack  output  1  read port A acknowledge, registered, one-cycle pulse
ra_data  output  DATA_W  read port A data, valid when ra_ack=1, held until next ack
rb_req  input  1  read port B request
rb_idx  input  IDX_W  read port B index
rb_ack  output  1  read port B acknowledge
rb_data  output  DATA_W  read port B data
w_req  input  1  write request
w_idx  input  IDX_W  write index
w_data  input  DATA_W  write data
w_ack  output  1  write acknowledge
rsv_req  input  1  reserve request (marks destination busy at issue)
rsv_idx  input  IDX_W  register to reserve
rsv_ack  output  1  reserve acknowledge
busy_vec  output  NUM_REGS  scoreboard, bit i = register i busy

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all registers 0, except reg[SP_IDX] = SP_INIT when SP_IDX != 0
  - busy_vec = 0
  - all acks = 0; ra_data = rb_data = 0
- Reset asserted mid-handshake aborts it; no ack is issued for an aborted request. After release, a request still held high is treated as new.
- Acceptance rule, all ports:
  - A request is evaluated in a cycle where req=1, own ack=0 and the port is not stalled.
  - On acceptance, ack=1 for exactly one cycle after the next rising edge.
  - Max throughput per port is one transaction per 2 cycles.
  - Requester must hold idx/data stable while req=1 and ack=0.
- Read (ports A and B are independent and identical):
  - Latency 1 cycle: data and ack are registered together.
  - idx=0 or idx>=NUM_REGS: data=0, no stall.
  - busy[idx]=0: data = reg[idx].
  - busy[idx]=1: stall (no ack) and re-evaluate every cycle.
  - Exception, write accepted same cycle to same idx (idx!=0):
    - BYPASS=1: data = w_data and the read is accepted even if busy.
    - BYPASS=0: a busy read stalls one more cycle, then returns the new value; a non-busy read returns the old value.
  - Both read ports may target the same register in the same cycle.
- Write:
  - Never stalls; 1-cycle ack.
  - Updates reg[w_idx] and clears busy[w_idx].
  - idx=0 or idx>=NUM_REGS: data dropped, still acked.
  - Writing a non-busy register is legal.
- Reserve:
  - idx=0 or out of range: acked, no state change.
  - busy[rsv_idx]=0: set busy, ack.
  - busy[rsv_idx]=1: stall (WAW hazard).
  - Evaluated against the busy value at the start of the cycle. A simultaneous write clearing the same index still stalls the reserve one cycle; the reserve is accepted the next cycle.
  - Reserve to index X and write to a different index Y in the same cycle: both take effect.
- busy_vec is registered; bit 0 is constant 0.
- No combinational path from any req input to any output.

Test Plan:
1. Reset release, DATA_W=32: read A idx 2 -> ra_data=0x00010000, ra_ack pulse 1 cycle after req; read B idx 5 -> 0.
2. Write idx 7 = 0xDEADBEEF, then read A and B idx 7 in the same cycle -> both return 0xDEADBEEF; write idx 0 = 0x1234 then read idx 0 -> 0.
3. Reserve idx 4 -> busy_vec[4]=1. Read A idx 4 held for 5 cycles -> no ack. Write idx 4 = 0x55 -> with BYPASS=1, ra_ack in the cycle after the write with data 0x55 and busy_vec[4]=0. With BYPASS=0, ack arrives one cycle later, still 0x55.
4. Reserve idx 9 twice -> second reserve stalls. Issue write idx 9 in the same cycle as the retried reserve -> reserve acks the following cycle and busy_vec[9] ends at 1.
5. Read idx 33 with NUM_REGS=32 -> data 0, acked; write idx 33 -> acked, no register changes.
6. Assert rst_n=0 while ra_req is stalled on a busy register -> ra_ack=0 immediately. After release: busy_vec=0, reg[2]=0x00010000, and the held request is acked 1 cycle after release with the reset value.
